// File: rtl/gray_pkg.sv
// Shared types and the Gray-to-binary helper for Gray-code consumers.
package gray_pkg;

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} rx_state_e;
  typedef enum logic [1:0] {HOLD, LEGAL, ILLEGAL} step_e;

  localparam int GRAY_MAX_W = 32;

  // Each binary bit is the XOR of all Gray bits at and above it. Callers
  // zero-extend narrower words, so the upper bits contribute nothing.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < GRAY_MAX_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

endpackage

// File: rtl/gray_rx_decoder_gray2bin.sv
// Combinational Gray-to-binary decode of a W-bit word.
module gray2bin
  import gray_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  assign o_bin = W'(gray_pkg::gray2bin(GRAY_MAX_W'(i_gray)));

endmodule

// File: rtl/gray_rx_decoder.sv
// Gray stream receiver: decodes to binary, checks single forward steps,
// locks onto the sequence and counts wrap-arounds.
module gray_rx_decoder
  import gray_pkg::*;
#(
  parameter int W        = 3,
  parameter int LOCK_CNT = 2,
  parameter int CW       = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          In_valid,
  input  logic [W-1:0]  Gray_in,
  input  logic          Clr_err,
  output logic [W-1:0]  Bin_out,
  output logic          Out_valid,
  output logic          Locked,
  output logic          Step_err,
  output logic          Err_sticky,
  output logic          Wrap,
  output logic [CW-1:0] Wrap_cnt
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);

  rx_state_e     r_state, w_nxt_state;
  logic [W-1:0]  r_ref, w_nxt_ref;
  logic [3:0]    r_good, w_nxt_good;
  logic [W-1:0]  w_bin;
  step_e         w_step;
  logic          w_step_err, w_wrap;

  logic [W-1:0]  r_bin;
  logic          r_out_valid, r_step_err, r_err_sticky, r_wrap;
  logic [CW-1:0] r_wrap_cnt;

  gray2bin #(.W(W)) u_g2b (.i_gray(Gray_in), .o_bin(w_bin));

  always_comb begin
    if (w_bin == r_ref)              w_step = HOLD;
    else if (w_bin == r_ref + 1'b1)  w_step = LEGAL;
    else                             w_step = ILLEGAL;
  end

  // State register; everything advances only on a valid sample.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= UNLOCKED;
      r_ref   <= '0;
      r_good  <= '0;
    end else if (In_valid) begin
      r_state <= w_nxt_state;
      r_ref   <= w_nxt_ref;
      r_good  <= w_nxt_good;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ref   = r_ref;
    w_nxt_good  = r_good;
    case (r_state)
      UNLOCKED: begin
        w_nxt_state = ACQUIRE;
        w_nxt_ref   = w_bin;
        w_nxt_good  = '0;
      end
      ACQUIRE: begin
        if (w_step == LEGAL) begin
          w_nxt_ref  = w_bin;
          w_nxt_good = r_good + 4'd1;
          if (r_good + 4'd1 >= LOCK_C) w_nxt_state = LOCKED;
        end else if (w_step == ILLEGAL) begin
          w_nxt_ref  = w_bin;
          w_nxt_good = '0;
        end
      end
      LOCKED: begin
        if (w_step == LEGAL) begin
          w_nxt_ref = w_bin;
        end else if (w_step == ILLEGAL) begin
          w_nxt_state = ACQUIRE;
          w_nxt_ref   = w_bin;
          w_nxt_good  = '0;
        end
      end
      default: w_nxt_state = UNLOCKED;
    endcase
  end

  always_comb begin
    w_step_err = (r_state == LOCKED) && (w_step == ILLEGAL);
    w_wrap     = (r_state == LOCKED) && (w_step == LEGAL) && (&r_ref);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_bin        <= '0;
      r_out_valid  <= 1'b0;
      r_step_err   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_wrap       <= 1'b0;
      r_wrap_cnt   <= '0;
    end else begin
      r_out_valid <= In_valid;
      r_step_err  <= In_valid & w_step_err;
      r_wrap      <= In_valid & w_wrap;
      if (In_valid) r_bin <= w_bin;
      if (In_valid && w_wrap && (r_wrap_cnt != '1)) r_wrap_cnt <= r_wrap_cnt + 1'b1;
      // A fresh error outranks a simultaneous clear.
      if (In_valid && w_step_err) r_err_sticky <= 1'b1;
      else if (Clr_err)           r_err_sticky <= 1'b0;
    end
  end

  assign Bin_out    = r_bin;
  assign Out_valid  = r_out_valid;
  assign Locked     = (r_state == LOCKED);
  assign Step_err   = r_step_err;
  assign Err_sticky = r_err_sticky;
  assign Wrap       = r_wrap;
  assign Wrap_cnt   = r_wrap_cnt;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Directed-vector bench for gray_rx_decoder (W=3, LOCK_CNT=2, CW=8).
module tb_gray_rx_decoder;

  logic       Clk = 1'b0;
  logic       Reset, In_valid, Clr_err;
  logic [2:0] Gray_in;
  logic [2:0] Bin_out;
  logic       Out_valid, Locked, Step_err, Err_sticky, Wrap;
  logic [7:0] Wrap_cnt;

  int n_chk = 0;
  int n_err = 0;

  gray_rx_decoder #(.W(3), .LOCK_CNT(2), .CW(8)) dut (
    .Clk(Clk), .Reset(Reset), .In_valid(In_valid), .Gray_in(Gray_in),
    .Clr_err(Clr_err), .Bin_out(Bin_out), .Out_valid(Out_valid),
    .Locked(Locked), .Step_err(Step_err), .Err_sticky(Err_sticky),
    .Wrap(Wrap), .Wrap_cnt(Wrap_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample the registered outputs after the edge.
  task automatic cyc(input logic v, input logic [2:0] g, input logic clr);
    In_valid = v; Gray_in = g; Clr_err = clr;
    @(posedge Clk); #1;
  endtask

  task automatic smp(input string tag, input logic [2:0] g, input logic [2:0] eb,
                     input logic el, input logic es, input logic ew);
    cyc(1'b1, g, 1'b0);
    chk({tag, ".bin"},  32'(Bin_out), 32'(eb));
    chk({tag, ".lock"}, 32'(Locked), 32'(el));
    chk({tag, ".serr"}, 32'(Step_err), 32'(es));
    chk({tag, ".wrap"}, 32'(Wrap), 32'(ew));
  endtask

  int serr_seen, wrap_seen;

  initial begin
    Reset = 1'b1; In_valid = 1'b0; Gray_in = '0; Clr_err = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst.bin",  32'(Bin_out), 0);
    chk("rst.ov",   32'(Out_valid), 0);
    chk("rst.lock", 32'(Locked), 0);
    chk("rst.wcnt", 32'(Wrap_cnt), 0);
    chk("rst.stk",  32'(Err_sticky), 0);
    Reset = 1'b0;

    // Acquire and lock
    smp("t1a", 3'b000, 3'd0, 0, 0, 0);
    chk("t1a.ov", 32'(Out_valid), 1);
    smp("t1b", 3'b001, 3'd1, 0, 0, 0);
    smp("t1c", 3'b011, 3'd2, 1, 0, 0);

    // Count up through wrap
    smp("t2a", 3'b010, 3'd3, 1, 0, 0);
    smp("t2b", 3'b110, 3'd4, 1, 0, 0);
    smp("t2c", 3'b111, 3'd5, 1, 0, 0);
    smp("t2d", 3'b101, 3'd6, 1, 0, 0);
    smp("t2e", 3'b100, 3'd7, 1, 0, 0);
    smp("t2f", 3'b000, 3'd0, 1, 0, 1);
    chk("t2.wcnt", 32'(Wrap_cnt), 1);

    // Skip 2 -> 4 while locked, then relock
    smp("t3a", 3'b001, 3'd1, 1, 0, 0);
    smp("t3b", 3'b011, 3'd2, 1, 0, 0);
    smp("t3c", 3'b110, 3'd4, 0, 1, 0);
    chk("t3c.stk", 32'(Err_sticky), 1);
    smp("t3d", 3'b111, 3'd5, 0, 0, 0);
    smp("t3e", 3'b101, 3'd6, 1, 0, 0);
    chk("t3e.stk", 32'(Err_sticky), 1);

    // Held value with idle gaps while locked
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 3'b011, 1'b0);
      chk("t4.gap_ov", 32'(Out_valid), 0);
      chk("t4.gap_bin", 32'(Bin_out), 6);
      smp("t4.hold", 3'b101, 3'd6, 1, 0, 0);
      chk("t4.ov", 32'(Out_valid), 1);
    end
    chk("t4.wcnt", 32'(Wrap_cnt), 1);

    // Clear coinciding with an error, then clear alone
    cyc(1'b1, 3'b001, 1'b1);
    chk("t5.serr", 32'(Step_err), 1);
    chk("t5.stk",  32'(Err_sticky), 1);
    chk("t5.bin",  32'(Bin_out), 1);
    cyc(1'b0, 3'b001, 1'b1);
    chk("t5.clr",  32'(Err_sticky), 0);
    chk("t5.serr0", 32'(Step_err), 0);
    Clr_err = 1'b0;

    // Relock from ref 1, then run 300 full cycles to saturate the wrap count
    smp("t6a", 3'b011, 3'd2, 0, 0, 0);
    smp("t6b", 3'b010, 3'd3, 1, 0, 0);
    serr_seen = 0; wrap_seen = 0;
    for (int k = 4; k < 4 + 300 * 8; k++) begin
      logic [2:0] b;
      b = 3'(k);
      cyc(1'b1, b ^ (b >> 1), 1'b0);
      if (Step_err) serr_seen++;
      if (Wrap) wrap_seen++;
    end
    chk("t6.serr_cnt", 32'(serr_seen), 0);
    chk("t6.wrap_cnt", 32'(wrap_seen), 300);
    chk("t6.wcnt_sat", 32'(Wrap_cnt), 255);
    chk("t6.lock", 32'(Locked), 1);

    // Reset mid-stream
    Reset = 1'b1;
    cyc(1'b1, 3'b100, 1'b0);
    Reset = 1'b0;
    chk("t6r.bin",  32'(Bin_out), 0);
    chk("t6r.ov",   32'(Out_valid), 0);
    chk("t6r.lock", 32'(Locked), 0);
    chk("t6r.wcnt", 32'(Wrap_cnt), 0);
    chk("t6r.stk",  32'(Err_sticky), 0);
    // First sample after reset is accepted without error regardless of value
    smp("t6r.a", 3'b101, 3'd6, 0, 0, 0);
    smp("t6r.b", 3'b100, 3'd7, 0, 0, 0);
    smp("t6r.c", 3'b000, 3'd0, 1, 0, 0);
    chk("t6r.wcnt2", 32'(Wrap_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
